// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter: round-robin scheduler that lets NREQ button-driven
// requesters share one FIFO, one write/read operation per button press.
module fifo_access_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           req_wr,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    input  logic                      full,
    input  logic                      empty,
    output logic                      wen,
    output logic                      ren,
    output logic [WIDTH-1:0]          fifo_din,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [NREQ-1:0]           done,
    output logic [NREQ-1:0]           reject,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        REJECT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    grant_nxt;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    win;
    logic             win_found;
    logic [NREQ-1:0]  sync1;
    logic [NREQ-1:0]  sync2;
    logic [NREQ-1:0]  sync3;
    logic [NREQ-1:0]  rise;
    logic [NREQ-1:0]  pending;
    logic [NREQ-1:0]  clr;
    logic [NREQ-1:0]  set_v;
    logic [NREQ-1:0]  dir;
    logic [WIDTH-1:0] data [NREQ];

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= req;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    // Leaving an action state releases the requester that was serviced.
    always_comb begin
        clr = '0;
        if (state != IDLE) begin
            clr[grant_id] = 1'b1;
        end
    end

    // An edge is taken only if nothing is outstanding for that requester,
    // or its outstanding request is retiring on this very edge.
    assign set_v = rise & (~pending | clr);

    // Request capture: pending flag, direction and write data per requester.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            dir     <= '0;
            for (int i = 0; i < NREQ; i++) begin
                data[i] <= '0;
            end
        end else begin
            pending <= (pending & ~clr) | set_v;
            for (int i = 0; i < NREQ; i++) begin
                if (set_v[i]) begin
                    dir[i]  <= req_wr[i];
                    data[i] <= wdata[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Round-robin search starting just after the last serviced requester.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!win_found && pending[IW'(idx)]) begin
                win_found = 1'b1;
                win       = IW'(idx);
            end
        end
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IW'(NREQ - 1);
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            if (state != IDLE) begin
                last_grant <= grant_id;
            end
        end
    end

    // Next state: IDLE picks a winner and checks full/empty once;
    // every action state lasts a single cycle.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        case (state)
            IDLE: begin
                if (|pending) begin
                    grant_nxt = win;
                    if (dir[win]) begin
                        state_nxt = full ? REJECT : WRITE;
                    end else begin
                        state_nxt = empty ? REJECT : READ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state and grant_id.
    always_comb begin
        wen      = 1'b0;
        ren      = 1'b0;
        fifo_din = '0;
        done     = '0;
        reject   = '0;
        busy     = (state != IDLE);
        case (state)
            WRITE: begin
                wen            = 1'b1;
                fifo_din       = data[grant_id];
                done[grant_id] = 1'b1;
            end
            READ: begin
                ren            = 1'b1;
                done[grant_id] = 1'b1;
            end
            REJECT: begin
                reject[grant_id] = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb_fifo_access_arbiter: directed stimulus with a queued scoreboard;
// a negedge monitor pops one expected operation per observed pulse.
module tb_fifo_access_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_wr = '0;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic              full = 1'b0;
    logic              empty = 1'b1;
    logic              wen;
    logic              ren;
    logic [WIDTH-1:0]  fifo_din;
    logic [1:0]        grant_id;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   reject;
    logic              busy;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    // kind: 0 = write, 1 = read, 2 = reject
    typedef struct {
        int         kind;
        int         id;
        logic [7:0] d;
        int         at;
    } exp_t;

    exp_t q[$];

    fifo_access_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .req_wr   (req_wr),
        .wdata    (wdata),
        .full     (full),
        .empty    (empty),
        .wen      (wen),
        .ren      (ren),
        .fifo_din (fifo_din),
        .grant_id (grant_id),
        .done     (done),
        .reject   (reject),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: invariants every cycle, scoreboard pop on every pulse.
    always @(negedge clock) begin
        logic       ev;
        exp_t       e;
        logic [3:0] oh;
        logic [3:0] x_done;
        logic [3:0] x_rej;
        logic [7:0] x_din;
        if (reset_n) begin
            ev = wen | ren | (|reject);
            total++;
            if ((wen && ren) || busy !== ev || (!wen && fifo_din !== 8'h00)
                || (!(wen || ren) && done !== 4'b0000)) begin
                bad++;
                $display("FAIL invariant cyc=%0d wen=%b ren=%b busy=%b din=%h done=%b rej=%b",
                         cyc, wen, ren, busy, fifo_din, done, reject);
            end
            if (ev) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_op cyc=%0d wen=%b ren=%b rej=%b gid=%0d din=%h",
                             cyc, wen, ren, reject, grant_id, fifo_din);
                end else begin
                    e = q.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    x_done = (e.kind < 2) ? oh : 4'b0000;
                    x_rej  = (e.kind == 2) ? oh : 4'b0000;
                    x_din  = (e.kind == 0) ? e.d : 8'h00;
                    if (wen !== (e.kind == 0) || ren !== (e.kind == 1)
                        || done !== x_done || reject !== x_rej
                        || fifo_din !== x_din || grant_id !== 2'(e.id)
                        || cyc != e.at) begin
                        bad++;
                        $display("FAIL op got cyc=%0d wen=%b ren=%b done=%b rej=%b din=%h gid=%0d want cyc=%0d kind=%0d id=%0d din=%h",
                                 cyc, wen, ren, done, reject, fifo_din, grant_id,
                                 e.at, e.kind, e.id, x_din);
                    end
                end
            end
        end
    end

    task automatic push(input int kind, input int id, input logic [7:0] d,
                        input int at);
        exp_t e;
        e.kind = kind;
        e.id   = id;
        e.d    = d;
        e.at   = at;
        q.push_back(e);
    endtask

    task automatic press(input int i, input logic wr, input logic [7:0] d);
        req_wr[i] = wr;
        wdata[i*WIDTH +: WIDTH] = d;
        req[i] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drain(input string name, input int lim);
        int n;
        n = 0;
        while (q.size() != 0 && n < lim) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_%s left=%0d required=0", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if (wen !== 1'b0 || ren !== 1'b0 || fifo_din !== 8'h00
            || grant_id !== 2'd0 || done !== 4'b0 || reject !== 4'b0
            || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s wen=%b ren=%b din=%h gid=%0d done=%b rej=%b busy=%b required all 0",
                     name, wen, ren, fifo_din, grant_id, done, reject, busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset asserted mid-cycle, outputs checked immediately.
        #3 reset_n = 1'b0;
        #1 check_zero("reset");
        idle(2);
        reset_n = 1'b1;
        idle(20);

        // Round robin from reset: 0,1,2,3 on alternate cycles.
        @(negedge clock);
        c = cyc;
        for (int i = 0; i < NREQ; i++) begin
            press(i, 1'b1, 8'h10 + 8'(i));
            push(0, i, 8'h10 + 8'(i), c + 4 + 2*i);
        end
        idle(12);
        req = '0;
        idle(6);
        drain("rr1", 10);

        // Second burst starts at 0 again because last_grant is 3.
        @(negedge clock);
        c = cyc;
        for (int i = 0; i < NREQ; i++) begin
            press(i, 1'b1, 8'h20 + 8'(i));
            push(0, i, 8'h20 + 8'(i), c + 4 + 2*i);
        end
        idle(12);
        req = '0;
        idle(6);
        drain("rr2", 10);

        // Single write, button held 50 cycles: one wen only.
        @(negedge clock);
        c = cyc;
        press(1, 1'b1, 8'hA5);
        push(0, 1, 8'hA5, c + 4);
        idle(50);
        req[1] = 1'b0;
        idle(5);
        drain("single", 10);

        // Read from empty FIFO is refused.
        empty = 1'b1;
        @(negedge clock);
        c = cyc;
        press(0, 1'b0, 8'h00);
        push(2, 0, 8'h00, c + 4);
        idle(8);
        req[0] = 1'b0;
        idle(5);
        drain("rej_read", 10);

        // Read from non-empty FIFO.
        empty = 1'b0;
        @(negedge clock);
        c = cyc;
        press(1, 1'b0, 8'h00);
        push(1, 1, 8'h00, c + 4);
        idle(8);
        req[1] = 1'b0;
        idle(5);
        drain("read", 10);

        // Write into full FIFO is refused.
        full = 1'b1;
        @(negedge clock);
        c = cyc;
        press(2, 1'b1, 8'h77);
        push(2, 2, 8'h00, c + 4);
        idle(8);
        req[2] = 1'b0;
        idle(5);
        drain("rej_write", 10);
        full = 1'b0;

        // Re-press edge lands on the clear edge: second op with new data.
        @(negedge clock);
        c = cyc;
        press(3, 1'b1, 8'h40);
        push(0, 3, 8'h40, c + 4);
        push(0, 3, 8'h41, c + 6);
        @(negedge clock);
        req[3] = 1'b0;
        @(negedge clock);
        req[3] = 1'b1;
        @(negedge clock);
        wdata[3*WIDTH +: WIDTH] = 8'h41;
        idle(10);
        req[3] = 1'b0;
        idle(6);
        drain("collide", 10);

        // Edge while still pending (queued behind 0) is ignored.
        @(negedge clock);
        c = cyc;
        press(0, 1'b1, 8'h30);
        press(3, 1'b1, 8'h60);
        push(0, 0, 8'h30, c + 4);
        push(0, 3, 8'h60, c + 6);
        @(negedge clock);
        req[3] = 1'b0;
        @(negedge clock);
        req[3] = 1'b1;
        @(negedge clock);
        wdata[3*WIDTH +: WIDTH] = 8'h61;
        idle(10);
        req = '0;
        idle(20);
        drain("ignored", 10);

        // Reset during the first write of a three-request burst.
        @(negedge clock);
        c = cyc;
        for (int i = 0; i < 3; i++) begin
            press(i, 1'b1, 8'h80 + 8'(i));
        end
        push(0, 0, 8'h80, c + 4);
        idle(4);
        #2 reset_n = 1'b0;
        req = '0;
        #1 check_zero("midreset");
        idle(2);
        reset_n = 1'b1;
        idle(30);
        drain("midreset", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
